udma_eth_frame_tx_ctrl: RTL and testbench
=========================================

Name: udma_eth_frame_tx_ctrl

Overview:
- TX transfer engine for the "ethernet frame" uDMA peripheral; sits directly downstream of the TX configuration registers.
- Consumes start address, size, continuous flag and the en/clr pulses from the register block.
- Fetches 32-bit words from L2 one request at a time and serialises them LSB-byte-first into an 8-bit frame stream with a last marker.
- Returns live status to the register block for readback: active, pending, current address, bytes left.

Parameters:
- L2_AWIDTH_NOAL, 12, byte-address width of L2 start and current address.
- TRANS_SIZE, 16, width of the transfer size and bytes-left counters (bytes).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  programmed start address (byte; bits [1:0] ignored, word-aligned).
- cfg_size_i  in  TRANS_SIZE  programmed transfer length in bytes.
- cfg_continuous_i  in  1  restart from the programmed values after completion.
- cfg_en_i  in  1  single-cycle start pulse.
- cfg_clr_i  in  1  single-cycle abort/clear pulse.
- cfg_en_o  out  1  transfer active.
- cfg_pending_o  out  1  a second start is queued.
- cfg_curr_addr_o  out  L2_AWIDTH_NOAL  address of the next word request.
- cfg_bytes_left_o  out  TRANS_SIZE  bytes not yet accepted on the stream.
- data_req_o  out  1  L2 read request.
- data_addr_o  out  L2_AWIDTH_NOAL  request address (word-aligned).
- data_gnt_i  in  1  request accepted.
- data_valid_i  in  1  read data returned; at most one per grant, at least 1 cycle after the grant.
- data_i  in  32  read data.
- tx_data_o  out  8  frame byte.
- tx_valid_o  out  1  byte valid.
- tx_ready_i  in  1  downstream accepts the byte.
- tx_last_o  out  1  final byte of the frame; qualified by tx_valid_o.

Behaviour:
- Reset (rst_i high, async): state IDLE.
  - All outputs 0.
  - cfg_curr_addr_o and cfg_bytes_left_o are 0.
  - Shadow (pending) registers cleared.
- States:
  - IDLE -> REQ on cfg_en_i when cfg_size_i != 0. Latches addr = cfg_startaddr_i & ~3, left = cfg_size_i, cont = cfg_continuous_i. cfg_en_i with size 0 is ignored.
  - REQ: data_req_o=1, data_addr_o=addr. On data_gnt_i, addr += 4 and the state goes to WAIT. The request stays asserted until granted.
  - WAIT: on data_valid_i, latch the word, set the byte index to 0, go to SEND.
  - SEND: tx_valid_o=1, tx_data_o = word byte[idx]. tx_last_o=1 when left==1.
    - On tx_valid_o & tx_ready_i: left -= 1, idx += 1.
    - If left becomes 0, the frame is done (see Completion below).
    - Otherwise, if idx was 3, go to REQ; else stay in SEND.
- Completion:
  - If pending is set, load the shadow values, clear pending, go to REQ.
  - Otherwise, if cont is set, reload the originally latched start and size, go to REQ.
  - Otherwise go to IDLE.
  - There is no idle cycle between frames in the pending and continuous cases.
- cfg_en_i while active: copy startaddr/size/continuous into the shadow and set pending. A second cfg_en_i while pending overwrites the shadow. Size 0 is ignored.
- cfg_clr_i: in the next cycle go to IDLE, clear pending, zero left; tx_valid_o and data_req_o drop.
  - If clr lands in WAIT, the outstanding data_valid_i is still absorbed and discarded. A drain flag holds until it arrives, and a new cfg_en_i in the meantime is queued as pending.
  - cfg_clr_i has priority over a simultaneous cfg_en_i; the en is dropped.
- cfg_en_o=1 in every state except IDLE.
- cfg_bytes_left_o = left; cfg_curr_addr_o = addr.
- Address arithmetic wraps modulo 2^L2_AWIDTH_NOAL.
- Partial last word: only the remaining bytes are sent, then completion.
- Byte-stream latency: the first tx_valid_o appears 1 cycle after data_valid_i.
- tx_valid_o, once high, stays high with stable data until accepted (except on cfg_clr_i).

Decomposition:
- Shared package udma_eth_frame_pkg:
  - state enum tx_state_e (IDLE, REQ, WAIT, SEND).
  - constant BYTES_PER_WORD = 4.
  - cfg bit positions EN_BIT=4, CLR_BIT=6, CONT_BIT=0, shared with the register block.
- Natural sub-module: udma_eth_frame_word2byte, a 32-to-8 unpacker holding the word, byte index and valid/ready handshake.

Test Plan:
- start=0x100, size=6, cont=0:
  - requests at 0x100, then 0x104.
  - bytes 0..5 LSB-first; tx_last_o on the 6th byte.
  - cfg_en_o falls after the last handshake; bytes_left reads 0.
- size=4, tx_ready_i toggled 1-0-1:
  - data stable while stalled; bytes_left steps 4,3,2,1,0 only on handshakes.
- size=2, cont=1:
  - after the 2nd byte, a new request to the start address issues with no IDLE cycle.
  - cfg_clr_i then returns to IDLE within 1 cycle with all outputs 0.
- Active transfer (size 8) plus cfg_en_i start=0x200, size=1:
  - pending=1 until the first frame ends; next request at 0x200.
  - one byte sent with tx_last_o; pending=0.
- cfg_clr_i during WAIT:
  - the following data_valid_i is dropped; no tx_valid_o.
  - a later start (size 4) transmits the correct new data.
- rst_i asserted mid-SEND:
  - outputs 0 asynchronously.
  - after release, cfg_en_i with size 0 keeps the block in IDLE.

Source files
------------

// File: rtl/udma_eth_frame_pkg.sv
// Shared types and constants for the uDMA ethernet-frame TX path.
// Bit positions are shared with the TX register block.
package udma_eth_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SEND
  } tx_state_e;

  localparam int BYTES_PER_WORD = 4;

  localparam int EN_BIT   = 4;
  localparam int CLR_BIT  = 6;
  localparam int CONT_BIT = 0;

endpackage

// File: rtl/udma_eth_frame_word2byte.sv
// 32-to-8 unpacker: holds one L2 word and hands it out LSB byte first.
// Valid drops after the 4th byte or when the frame's last byte is taken.
module udma_eth_frame_word2byte
  import udma_eth_frame_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        flush_i,
  input  logic        last_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        hs_o,
  output logic        idx_last_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        valid_q;

  assign hs_o       = valid_q & tx_ready_i;
  assign idx_last_o = idx_q == 2'(BYTES_PER_WORD - 1);
  assign tx_valid_o = valid_q;
  assign tx_data_o  = valid_q ? word_q[{idx_q, 3'b000} +: 8] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (hs_o) begin
      idx_q <= idx_q + 2'd1;
      if (idx_last_o || last_i) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/udma_eth_frame_tx_ctrl.sv
// TX transfer engine: fetches L2 words one request at a time and
// streams them as bytes, with a one-deep queue for a second start.
module udma_eth_frame_tx_ctrl
  import udma_eth_frame_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  output logic                      data_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] data_addr_o,
  input  logic                      data_gnt_i,
  input  logic                      data_valid_i,
  input  logic [31:0]               data_i,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic                      tx_last_o
);

  localparam int AW = L2_AWIDTH_NOAL;
  localparam int SW = TRANS_SIZE;

  tx_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, base_q, base_d;
  logic [AW-1:0] sh_addr_q, sh_addr_d;
  logic [SW-1:0] left_q, left_d, size_q, size_d;
  logic [SW-1:0] sh_size_q, sh_size_d;
  logic          cont_q, cont_d, sh_cont_q, sh_cont_d;
  logic          pend_q, pend_d, drain_q, drain_d;

  logic          en_ok, go_next, launch;
  logic          load, hs, idx_last, end_byte;
  logic [AW-1:0] start_al, nx_addr;
  logic [SW-1:0] nx_size;
  logic          nx_cont;

  assign start_al = cfg_startaddr_i & ~AW'(3);
  assign en_ok    = cfg_en_i & ~cfg_clr_i
                  & (cfg_size_i != '0);
  assign go_next  = pend_q | en_ok;
  // A start arriving this cycle supersedes the queued one.
  assign nx_addr  = en_ok ? start_al : sh_addr_q;
  assign nx_size  = en_ok ? cfg_size_i : sh_size_q;
  assign nx_cont  = en_ok ? cfg_continuous_i : sh_cont_q;
  assign end_byte = left_q == SW'(1);
  assign load     = (state_q == WAIT) & data_valid_i
                  & ~cfg_clr_i;

  udma_eth_frame_word2byte u_w2b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .word_i     (data_i),
    .flush_i    (cfg_clr_i),
    .last_i     (end_byte),
    .tx_ready_i (tx_ready_i),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .hs_o       (hs),
    .idx_last_o (idx_last)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    left_d    = left_q;
    size_d    = size_q;
    cont_d    = cont_q;
    sh_addr_d = sh_addr_q;
    sh_size_d = sh_size_q;
    sh_cont_d = sh_cont_q;
    pend_d    = pend_q;
    drain_d   = drain_q;
    launch    = 1'b0;
    if (cfg_clr_i) begin
      state_d = IDLE;
      addr_d  = '0;
      left_d  = '0;
      pend_d  = 1'b0;
      // A granted read still owes us one data beat.
      drain_d = (drain_q & ~data_valid_i)
              | ((state_q == WAIT) & ~data_valid_i)
              | ((state_q == REQ) & data_gnt_i);
    end else begin
      if (en_ok && (state_q != IDLE || drain_q)) begin
        sh_addr_d = start_al;
        sh_size_d = cfg_size_i;
        sh_cont_d = cfg_continuous_i;
        pend_d    = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (drain_q) drain_d = ~data_valid_i;
          else         launch  = go_next;
        end
        REQ: begin
          if (data_gnt_i) begin
            addr_d  = addr_q + AW'(BYTES_PER_WORD);
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (data_valid_i) state_d = SEND;
        end
        SEND: begin
          if (hs) begin
            left_d = left_q - SW'(1);
            if (end_byte) begin
              if (go_next) begin
                launch = 1'b1;
              end else if (cont_q) begin
                addr_d  = base_q;
                left_d  = size_q;
                state_d = REQ;
              end else begin
                state_d = IDLE;
              end
            end else if (idx_last) begin
              state_d = REQ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (launch) begin
        addr_d  = nx_addr;
        base_d  = nx_addr;
        left_d  = nx_size;
        size_d  = nx_size;
        cont_d  = nx_cont;
        pend_d  = 1'b0;
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      left_q    <= '0;
      size_q    <= '0;
      cont_q    <= 1'b0;
      sh_addr_q <= '0;
      sh_size_q <= '0;
      sh_cont_q <= 1'b0;
      pend_q    <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      left_q    <= left_d;
      size_q    <= size_d;
      cont_q    <= cont_d;
      sh_addr_q <= sh_addr_d;
      sh_size_q <= sh_size_d;
      sh_cont_q <= sh_cont_d;
      pend_q    <= pend_d;
      drain_q   <= drain_d;
    end
  end

  assign cfg_en_o         = state_q != IDLE;
  assign cfg_pending_o    = pend_q;
  assign cfg_curr_addr_o  = addr_q;
  assign cfg_bytes_left_o = left_q;
  assign data_req_o       = state_q == REQ;
  assign data_addr_o      = data_req_o ? addr_q : '0;
  assign tx_last_o        = tx_valid_o & end_byte;

endmodule

// File: tb/tb_udma_eth_frame_tx_ctrl.sv
// Randomised bench: L2 responder plus byte-stream scoreboard built
// from a frame-level model (address + k, LSB first, last on final byte).
module tb_udma_eth_frame_tx_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] cfg_startaddr_i;
  logic [15:0] cfg_size_i;
  logic        cfg_continuous_i, cfg_en_i, cfg_clr_i;
  logic        cfg_en_o, cfg_pending_o;
  logic [11:0] cfg_curr_addr_o;
  logic [15:0] cfg_bytes_left_o;
  logic        data_req_o;
  logic [11:0] data_addr_o;
  logic        data_gnt_i, data_valid_i;
  logic [31:0] data_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i, tx_last_o;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         left;
  } exp_t;

  exp_t        exp_b[$];
  logic [11:0] exp_r[$];
  int          nvec = 0;
  int          errs = 0;
  int          rdy_mode = 1;
  bit          stab_on = 1'b1;
  int          rsp_dly = 0;
  logic [31:0] seed;

  udma_eth_frame_tx_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cfg_startaddr_i  (cfg_startaddr_i),
    .cfg_size_i       (cfg_size_i),
    .cfg_continuous_i (cfg_continuous_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_clr_i        (cfg_clr_i),
    .cfg_en_o         (cfg_en_o),
    .cfg_pending_o    (cfg_pending_o),
    .cfg_curr_addr_o  (cfg_curr_addr_o),
    .cfg_bytes_left_o (cfg_bytes_left_o),
    .data_req_o       (data_req_o),
    .data_addr_o      (data_addr_o),
    .data_gnt_i       (data_gnt_i),
    .data_valid_i     (data_valid_i),
    .data_i           (data_i),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .tx_last_o        (tx_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 4'h5, ~a[7:0], a[11:4]} ^ seed;
  endfunction

  function automatic void push_frame(input logic [11:0] a, input int size);
    logic [11:0] base;
    logic [11:0] wa;
    logic [31:0] w;
    exp_t        e;
    base = a & 12'hFFC;
    for (int k = 0; k < size; k++) begin
      wa     = base + 12'(4 * (k / 4));
      w      = mem_word(wa);
      e.data = w[8*(k%4) +: 8];
      e.last = (k == size - 1);
      e.left = size - k;
      exp_b.push_back(e);
      if (k % 4 == 0) exp_r.push_back(wa);
    end
  endfunction

  task automatic start(input logic [11:0] a, input int sz, input bit cont);
    cfg_startaddr_i  = a;
    cfg_size_i       = 16'(sz);
    cfg_continuous_i = cont;
    cfg_en_i         = 1'b1;
    @(negedge clk_i);
    cfg_en_i = 1'b0;
  endtask

  task automatic clear();
    cfg_clr_i = 1'b1;
    @(negedge clk_i);
    cfg_clr_i = 1'b0;
  endtask

  task automatic check_quiet(input string t);
    check({t, "_en"},   32'(cfg_en_o), 0);
    check({t, "_pend"}, 32'(cfg_pending_o), 0);
    check({t, "_addr"}, 32'(cfg_curr_addr_o), 0);
    check({t, "_left"}, 32'(cfg_bytes_left_o), 0);
    check({t, "_req"},  32'({data_req_o, data_addr_o}), 0);
    check({t, "_tx"},   32'({tx_valid_o, tx_last_o, tx_data_o}), 0);
  endtask

  task automatic wait_done(input string t, input int max);
    int n;
    n = 0;
    while ((exp_b.size() != 0 || cfg_en_o) && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check({t, "_done"},  32'(n < max), 1);
    check({t, "_left0"}, 32'(cfg_bytes_left_o), 0);
  endtask

  // L2 responder: random grant, data 1+ cycles after the grant
  initial begin
    int          cnt;
    bit          busy;
    logic [11:0] ra;
    data_gnt_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
    busy = 1'b0; cnt = 0; ra = '0;
    forever begin
      @(negedge clk_i);
      data_gnt_i = 1'b0; data_valid_i = 1'b0;
      if (rst_i) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt == 0) begin
          data_valid_i = 1'b1; data_i = mem_word(ra); busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (data_req_o && $urandom_range(0, 2) != 0) begin
        data_gnt_i = 1'b1; ra = data_addr_o; busy = 1'b1;
        cnt = rsp_dly + $urandom_range(0, 2);
        if (exp_r.size() == 0)
          check("req_unexp", 32'(data_addr_o), 32'hFFFF_FFFF);
        else
          check("req_addr", 32'(data_addr_o), 32'(exp_r.pop_front()));
      end
    end
  end

  // Byte sink: drives ready, checks stalls and each accepted byte
  initial begin
    logic        pv, pl;
    logic [7:0]  pd;
    logic [15:0] pleft;
    exp_t        e;
    tx_ready_i = 1'b0; pv = 1'b0; pl = 1'b0; pd = '0; pleft = '0;
    forever begin
      @(negedge clk_i);
      if (stab_on && pv && !rst_i) begin
        check("stall_valid", 32'(tx_valid_o), 1);
        check("stall_data", 32'({tx_data_o, tx_last_o}), 32'({pd, pl}));
        check("stall_left", 32'(cfg_bytes_left_o), 32'(pleft));
      end
      case (rdy_mode)
        0:       tx_ready_i = 1'b0;
        1:       tx_ready_i = 1'b1;
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
      pv = tx_valid_o && !tx_ready_i;
      pd = tx_data_o; pl = tx_last_o; pleft = cfg_bytes_left_o;
      if (tx_valid_o && tx_ready_i && !rst_i) begin
        if (exp_b.size() == 0) begin
          check("tx_unexp", 32'(tx_data_o), 32'h1FF);
        end else begin
          e = exp_b.pop_front();
          check("tx_data", 32'(tx_data_o), 32'(e.data));
          check("tx_last", 32'(tx_last_o), 32'(e.last));
          check("tx_left", 32'(cfg_bytes_left_o), e.left);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int          n;
    bit          idle_seen;
    logic [11:0] a;
    int          sz;
    seed = $urandom;
    rst_i = 1'b1; cfg_startaddr_i = '0; cfg_size_i = '0;
    cfg_continuous_i = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_quiet("rst");
    rst_i = 1'b0;
    @(negedge clk_i);

    // 6-byte frame at 0x100, two word requests
    rdy_mode = 1;
    push_frame(12'h100, 6);
    start(12'h100, 6, 1'b0);
    n = 0;
    do begin @(posedge clk_i); n++; end
    while (!data_valid_i && n < 50);
    @(negedge clk_i);
    check("t1_latency", 32'(tx_valid_o), 1);
    check("t1_left6", 32'(cfg_bytes_left_o), 6);
    wait_done("t1", 200);
    check("t1_en_off", 32'(cfg_en_o), 0);

    // 4 bytes under random back-pressure
    rdy_mode = 2;
    push_frame(12'h1F0, 4);
    start(12'h1F0, 4, 1'b0);
    wait_done("t2", 300);

    // continuous 2-byte frames, then clear
    rdy_mode = 1;
    repeat (3) push_frame(12'h080, 2);
    start(12'h080, 2, 1'b1);
    idle_seen = 1'b0; n = 0;
    while (exp_b.size() > 2 && n < 200) begin
      @(negedge clk_i);
      n++;
      if (!cfg_en_o) idle_seen = 1'b1;
    end
    check("t3_noidle", 32'(idle_seen), 0);
    check("t3_time", 32'(n < 200), 1);
    rdy_mode = 0;
    stab_on = 1'b0;
    @(negedge clk_i);
    clear();
    check_quiet("t3_clr");
    repeat (10) @(negedge clk_i);
    exp_b.delete(); exp_r.delete();
    stab_on = 1'b1;

    // queued start while active
    rdy_mode = 2;
    push_frame(12'h040, 8);
    push_frame(12'h200, 1);
    start(12'h040, 8, 1'b0);
    start(12'h200, 1, 1'b0);
    check("t4_pend", 32'(cfg_pending_o), 1);
    n = 0;
    while (cfg_pending_o && n < 300) begin @(negedge clk_i); n++; end
    check("t4_pend_clr", 32'(cfg_pending_o), 0);
    check("t4_active", 32'(cfg_en_o), 1);
    check("t4_remain", 32'(exp_b.size()), 1);
    wait_done("t4", 200);

    // clear in WAIT, new start while the stale beat drains
    rdy_mode = 1; rsp_dly = 6;
    push_frame(12'h300, 4);
    start(12'h300, 4, 1'b0);
    n = 0;
    do begin @(posedge clk_i); n++; end
    while (!data_gnt_i && n < 50);
    @(negedge clk_i);
    stab_on = 1'b0;
    clear();
    exp_b.delete(); exp_r.delete();
    stab_on = 1'b1;
    check("t5_clr_tx", 32'(tx_valid_o), 0);
    push_frame(12'h400, 4);
    start(12'h400, 4, 1'b0);
    check("t5_pend", 32'(cfg_pending_o), 1);
    check("t5_en", 32'(cfg_en_o), 0);
    wait_done("t5", 300);
    rsp_dly = 0;

    // async reset mid-SEND, then a size-0 start
    rdy_mode = 0;
    push_frame(12'h500, 12);
    start(12'h500, 12, 1'b0);
    n = 0;
    while (!tx_valid_o && n < 50) begin @(negedge clk_i); n++; end
    check("t6_send", 32'(tx_valid_o), 1);
    stab_on = 1'b0;
    #1 rst_i = 1'b1;
    #1 check_quiet("t6_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_b.delete(); exp_r.delete();
    stab_on = 1'b1;
    start(12'h600, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t6_size0", 32'({cfg_en_o, data_req_o}), 0);
      @(negedge clk_i);
    end

    // random frames, some with a queued follower or a size-0 start
    rdy_mode = 2;
    for (int it = 0; it < 16; it++) begin
      a = 12'($urandom);
      if (it == 3) a = 12'hFF8;
      sz = $urandom_range(1, 13);
      rsp_dly = $urandom_range(0, 2);
      push_frame(a, sz);
      start(a, sz, 1'b0);
      if (it % 5 == 0) start(12'($urandom), 0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        a = 12'($urandom);
        sz = $urandom_range(1, 9);
        push_frame(a, sz);
        start(a, sz, 1'b0);
      end
      wait_done("rnd", 600);
    end

    repeat (5) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
